bicubic_window_scheduler: RTL and testbench

Sequences the bicubic upsample datapath for one colour channel. Reads 4-row column slices from the external line buffer, builds the 4×4 source windows with edge clamping, and replays each source-row group four times, once per vertical phase. Hands windows to the upsample datapath over a valid/ready handshake and tells the line buffer when a row group can be released.

---
 rtl/bicubic_window_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_bicubic_window_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_window_scheduler.sv
// Bicubic window scheduler: fetches 4-row column slices from the line buffer,
// assembles edge-clamped 4x4 windows, replays each row group once per vertical
// phase and hands windows to the upsample datapath through a 2-entry FIFO.
module bicubic_window_scheduler #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned BLOCK_SIZE    = 960,
  parameter int unsigned SRC_HEIGHT    = 540,
  localparam int unsigned GW  = (SRC_HEIGHT > 1) ? $clog2(SRC_HEIGHT) : 1,
  localparam int unsigned CAW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       frame_done,
  input  logic                       lb_row_valid,
  output logic [GW-1:0]              lb_row_group,
  output logic                       lb_row_release,
  output logic                       lb_rd_en,
  output logic [CAW-1:0]             lb_rd_col,
  input  logic [4*CHANNEL_WIDTH-1:0] lb_rd_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [16*CHANNEL_WIDTH-1:0] win_data,
  output logic [1:0]                 win_phase,
  output logic                       win_last_col,
  output logic                       win_last_row
);

  localparam int unsigned JW = $clog2(BLOCK_SIZE + 4) + 1;
  localparam int unsigned SW = 4 * CHANNEL_WIDTH;
  localparam int unsigned WW = 16 * CHANNEL_WIDTH;
  localparam logic [JW-1:0] LastJ     = JW'(BLOCK_SIZE + 3);
  localparam logic [GW-1:0] LastGroup = GW'(SRC_HEIGHT - 1);

  typedef enum logic [2:0] {StIdle, StWaitRow, StRun, StDrain, StAdv} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] group_q, group_d;
  logic [1:0]    phase_q, phase_d;
  logic [JW-1:0] rd_j_q, rd_j_d;        // index of the next read in this pass
  logic          rd_pend_q;             // a read was issued last cycle
  logic [JW-1:0] rd_pend_j_q;           // index of that read

  // Three most recent slices, [0] oldest; the returning slice forms column 3.
  logic [SW-1:0] slice_q [3];

  logic [WW-1:0] fifo_data_q  [2];
  logic [1:0]    fifo_phase_q [2];
  logic          fifo_lc_q    [2];
  logic          fifo_lr_q    [2];
  logic          fifo_wr_q, fifo_rd_q;
  logic [1:0]    fifo_cnt_q;

  logic          push, pop, issue;
  logic [2:0]    occ;
  logic [WW-1:0] win_new;

  // Handshake and read-issue bookkeeping
  assign win_valid = (fifo_cnt_q != 2'd0);
  assign pop       = win_valid & win_ready;
  assign occ       = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, rd_pend_q};
  assign issue     = (state_q == StRun) && (occ < 3'd2);
  assign push      = rd_pend_q && (rd_pend_j_q >= JW'(3));

  assign lb_rd_en     = issue;
  assign busy         = (state_q != StIdle);
  assign lb_row_group = group_q;

  // Column address clamped to the row edges
  always_comb begin
    lb_rd_col = '0;
    if (rd_j_q < JW'(2)) begin
      lb_rd_col = '0;
    end else if ((rd_j_q - JW'(2)) >= JW'(BLOCK_SIZE)) begin
      lb_rd_col = CAW'(BLOCK_SIZE - 1);
    end else begin
      lb_rd_col = CAW'(rd_j_q - JW'(2));
    end
  end

  // Assemble the window completed by the returning slice
  always_comb begin
    win_new = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_new[(4*r+c)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
          slice_q[c][r*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      end
      win_new[(4*r+3)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
        lb_rd_data[r*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end
  end

  // FIFO head drives the window outputs; zero while empty
  always_comb begin
    win_data     = '0;
    win_phase    = '0;
    win_last_col = 1'b0;
    win_last_row = 1'b0;
    if (win_valid) begin
      win_data     = fifo_data_q[fifo_rd_q];
      win_phase    = fifo_phase_q[fifo_rd_q];
      win_last_col = fifo_lc_q[fifo_rd_q];
      win_last_row = fifo_lr_q[fifo_rd_q];
    end
  end

  // Next-state logic for pass sequencing, phase replay and group release
  always_comb begin
    state_d        = state_q;
    group_d        = group_q;
    phase_d        = phase_q;
    rd_j_d         = rd_j_q;
    lb_row_release = 1'b0;
    frame_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitRow;
          group_d = '0;
          phase_d = 2'd0;
        end
      end
      StWaitRow: begin
        rd_j_d = '0;
        if (lb_row_valid) state_d = StRun;
      end
      StRun: begin
        if (issue) begin
          rd_j_d = rd_j_q + JW'(1);
          if (rd_j_q == LastJ) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((fifo_cnt_q == 2'd0) && !rd_pend_q) state_d = StAdv;
      end
      StAdv: begin
        if (phase_q != 2'd3) begin
          phase_d = phase_q + 2'd1;
          state_d = StWaitRow;
        end else begin
          lb_row_release = 1'b1;
          if (group_q == LastGroup) begin
            frame_done = 1'b1;
            state_d    = StIdle;
          end else begin
            group_d = group_q + GW'(1);
            phase_d = 2'd0;
            state_d = StWaitRow;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      group_q     <= '0;
      phase_q     <= 2'd0;
      rd_j_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_pend_j_q <= '0;
    end else begin
      state_q     <= state_d;
      group_q     <= group_d;
      phase_q     <= phase_d;
      rd_j_q      <= rd_j_d;
      rd_pend_q   <= issue;
      rd_pend_j_q <= rd_j_q;
    end
  end

  // Column shift register: returning slices enter at the newest position
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) slice_q[i] <= '0;
    end else if (rd_pend_q) begin
      slice_q[0] <= slice_q[1];
      slice_q[1] <= slice_q[2];
      slice_q[2] <= lb_rd_data;
    end
  end

  // Two-entry window FIFO; the issue rule keeps it from overflowing
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_phase_q[i] <= 2'd0;
        fifo_lc_q[i]    <= 1'b0;
        fifo_lr_q[i]    <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data_q[fifo_wr_q]  <= win_new;
        fifo_phase_q[fifo_wr_q] <= phase_q;
        fifo_lc_q[fifo_wr_q]    <= (rd_pend_j_q == LastJ);
        fifo_lr_q[fifo_wr_q]    <= (group_q == LastGroup) && (phase_q == 2'd3);
        fifo_wr_q               <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bicubic_window_scheduler.sv
// Self-checking bench for bicubic_window_scheduler with W=8, H=3.
module tb_bicubic_window_scheduler;

  localparam int W  = 8;
  localparam int H  = 3;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy, frame_done;
  logic         lb_row_valid = 1'b1;
  logic [1:0]   lb_row_group;
  logic         lb_row_release;
  logic         lb_rd_en;
  logic [2:0]   lb_rd_col;
  logic [31:0]  lb_rd_data = '0;
  logic         win_valid;
  logic         win_ready;
  logic [127:0] win_data;
  logic [1:0]   win_phase;
  logic         win_last_col, win_last_row;

  always #5 clk = ~clk;

  bicubic_window_scheduler #(
    .CHANNEL_WIDTH(CW),
    .BLOCK_SIZE   (W),
    .SRC_HEIGHT   (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .frame_done    (frame_done),
    .lb_row_valid  (lb_row_valid),
    .lb_row_group  (lb_row_group),
    .lb_row_release(lb_row_release),
    .lb_rd_en      (lb_rd_en),
    .lb_rd_col     (lb_rd_col),
    .lb_rd_data    (lb_rd_data),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .win_data      (win_data),
    .win_phase     (win_phase),
    .win_last_col  (win_last_col),
    .win_last_row  (win_last_row)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model -------------------------------------------------------
  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   phase;
    logic         lc;
    logic         lr;
  } win_t;

  win_t       win_q[$];
  logic [4:0] col_q[$];   // {group, column} of each expected read

  function automatic int clampc(input int x);
    if (x < 0) return 0;
    if (x > W - 1) return W - 1;
    return x;
  endfunction

  function automatic logic [31:0] slice(input logic [2:0] c, input logic [1:0] g);
    logic [31:0] s;
    for (int r = 0; r < 4; r++) s[r*8 +: 8] = 8'(int'(g) * 32 + int'(c) * 4 + r);
    return s;
  endfunction

  task automatic build_frame();
    win_t w;
    for (int g = 0; g < H; g++) begin
      for (int p = 0; p < 4; p++) begin
        for (int j = 0; j < W + 4; j++) col_q.push_back({2'(g), 3'(clampc(j - 2))});
        for (int k = 0; k <= W; k++) begin
          w.data = '0;
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              w.data[(4*r+c)*8 +: 8] = 8'(g * 32 + 4 * clampc(k - 2 + c) + r);
          w.phase = 2'(p);
          w.lc    = (k == W);
          w.lr    = (g == H - 1) && (p == 3);
          win_q.push_back(w);
        end
      end
    end
  endtask

  // Line buffer responder -------------------------------------------------
  int stall_len = 0;   // 0: random 1..3 cycle reload gap
  int delay_cnt = 0;

  always @(posedge clk) begin
    lb_rd_data <= lb_rd_en ? slice(lb_rd_col, lb_row_group) : 32'($urandom);
    if (rst) begin
      lb_row_valid <= 1'b1;
      delay_cnt    <= 0;
    end else if (lb_row_release) begin
      lb_row_valid <= 1'b0;
      delay_cnt    <= (stall_len > 0) ? stall_len : int'($urandom_range(1, 3));
    end else if (delay_cnt > 0) begin
      delay_cnt <= delay_cnt - 1;
      if (delay_cnt == 1) lb_row_valid <= 1'b1;
    end
  end

  bit rand_ready = 1'b0;
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor ---------------------------------------------------------------
  int         occ = 0;          // windows held in the FIFO
  bit         pend = 1'b0;      // read issued last cycle
  int         pend_idx = 0;
  int         rd_pass_idx = 0;
  int         pops_grp = 0;
  int         rel_in_frame = 0;
  bit         busy_exp = 1'b0;
  bit         pop_s, push_s;
  logic [4:0] e_col;
  win_t       e_win;

  always @(negedge clk) begin
    if (rst) begin
      occ = 0; pend = 0; pend_idx = 0; rd_pass_idx = 0;
      pops_grp = 0; rel_in_frame = 0; busy_exp = 0;
    end else begin
      pop_s = win_valid && win_ready;
      check("busy", busy, busy_exp);
      check("win_valid", win_valid, occ != 0);
      if (!rand_ready && rd_pass_idx != 0) check("rd_back_to_back", lb_rd_en, 1);
      if (lb_rd_en) begin
        check("issue_rule", (occ - int'(pop_s) + int'(pend)) < 2, 1);
        check("rd_without_row", lb_row_valid, 1);
        if (col_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e_col = col_q.pop_front();
          check("rd_addr", {lb_row_group, lb_rd_col}, e_col);
        end
      end
      if (pop_s) begin
        if (win_q.size() == 0) check("win_unexpected", 1, 0);
        else begin
          e_win = win_q.pop_front();
          check("win_data", win_data, e_win.data);
          check("win_phase", win_phase, e_win.phase);
          check("win_last_col", win_last_col, e_win.lc);
          check("win_last_row", win_last_row, e_win.lr);
        end
        pops_grp++;
      end
      if (lb_row_release || frame_done) begin
        check("release_pulse", lb_row_release, 1);
        check("release_pop_count", pops_grp, 4 * (W + 1));
        check("release_fifo_empty", occ, 0);
        check("frame_done", frame_done, rel_in_frame == H - 1);
        rel_in_frame = frame_done ? 0 : rel_in_frame + 1;
        pops_grp = 0;
      end
      push_s = pend && (pend_idx >= 3);
      occ = occ + int'(push_s) - int'(pop_s);
      if (push_s || pop_s) check("fifo_bound", occ <= 2, 1);
      pend     = lb_rd_en;
      pend_idx = rd_pass_idx;
      if (lb_rd_en) rd_pass_idx = (rd_pass_idx == W + 3) ? 0 : rd_pass_idx + 1;
      busy_exp = (start && !busy_exp) ? 1'b1 : (frame_done ? 1'b0 : busy_exp);
    end
  end

  // Stimulus --------------------------------------------------------------
  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {busy, frame_done, lb_row_release, lb_rd_en, lb_rd_col, lb_row_group,
                           win_valid, win_phase, win_last_col, win_last_row}, '0);
    check({tag, "_data"}, win_data, '0);
  endtask

  task automatic run_frame(input int mid_start);
    bit done = 1'b0;
    build_frame();
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      start = (i == mid_start);
      @(negedge clk);
      if (frame_done) begin
        done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("frame_timeout", done, 1);
    check("win_left", win_q.size(), 0);
    check("rd_left", col_q.size(), 0);
    win_q.delete();
    col_q.delete();
  endtask

  initial begin
    int  n_rd;
    bit  hit;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Frame with win_ready held high
    run_frame(-1);

    // Back-to-back frame: random ready, long reload stalls, stray start mid-frame
    rand_ready = 1'b1;
    stall_len  = 10;
    run_frame(60);
    stall_len  = 0;
    rand_ready = 1'b0;

    // Reset the cycle after read j=3 of pass 2 issues
    build_frame();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_rd = 0;
    hit  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (lb_rd_en) n_rd++;
      if (n_rd == W + 4 + 4) begin
        hit = 1'b1;
        break;
      end
    end
    check("reset_point_timeout", hit, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    win_q.delete();
    col_q.delete();
    @(negedge clk);
    check_zero("mid_reset");

    // Fresh frame after the reset starts over at group 0, phase 0
    run_frame(-1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
